// File: rtl/tt_uart_tx.sv
// tt_uart_tx: byte-serial 8N1 UART transmitter with a small transmit FIFO.
// Bytes enter through a valid/ready write port, are queued, and are sent
// LSB first at CLK_DIV clocks per bit. tx is driven from a flop.
// Optional even-parity bit between data and stop: define TT_UART_TX_PARITY_EN.
module tt_uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic       tx,
  output logic       busy,
  output logic [4:0] fifo_count
);

  localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0]  DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [4:0]  DEPTH  = 5'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef TT_UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  // FIFO storage and pointers
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count_n;
  logic          push;
  logic          pop;

  // Transmitter state
  state_t     state, state_n;
  logic [7:0] baud_cnt, baud_cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n;
  logic       tx_n;
  logic       start_cond;
  logic       boundary;

  assign wr_ready   = (fifo_count != DEPTH);
  assign push       = wr_valid & wr_ready;
  assign start_cond = (fifo_count != 5'd0) & ena;
  assign boundary   = (baud_cnt == 8'd0);
  assign busy       = (state != S_IDLE) | (fifo_count != 5'd0);

  // FIFO data array; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_n;
    end
  end

  // Occupancy next value: simultaneous push and pop leaves it unchanged
  always_comb begin
    count_n = fifo_count;
    case ({push, pop})
      2'b10:   count_n = fifo_count + 5'd1;
      2'b01:   count_n = fifo_count - 5'd1;
      default: count_n = fifo_count;
    endcase
  end

  // Transmitter state register; tx is registered so the line never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      tx       <= tx_n;
    end
  end

  // Next-state, baud timing, pop request and next tx level
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    tx_n       = tx;
    pop        = 1'b0;

    if (state == S_IDLE) begin
      tx_n = 1'b1;
      if (start_cond) begin
        pop        = 1'b1;
        shift_n    = mem[rd_ptr];
        state_n    = S_START;
        tx_n       = 1'b0;
        baud_cnt_n = DIV_M1;
      end
    end else if (!boundary) begin
      baud_cnt_n = baud_cnt - 8'd1;
    end else begin
      baud_cnt_n = DIV_M1;
      case (state)
        S_START: begin
          state_n   = S_DATA;
          bit_idx_n = 3'd0;
          tx_n      = shift[0];
        end
        S_DATA: begin
          if (bit_idx == 3'd7) begin
`ifdef TT_UART_TX_PARITY_EN
            state_n = S_PARITY;
            tx_n    = ^shift;
`else
            state_n = S_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shift[bit_idx + 3'd1];
          end
        end
`ifdef TT_UART_TX_PARITY_EN
        S_PARITY: begin
          state_n = S_STOP;
          tx_n    = 1'b1;
        end
`endif
        S_STOP: begin
          // Chain straight into the next start bit when a byte is waiting
          if (start_cond) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = S_START;
            tx_n    = 1'b0;
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end
        default: begin
          state_n = S_IDLE;
          tx_n    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_uart_tx.sv
// tb_tt_uart_tx: directed bench for tt_uart_tx at CLK_DIV=4, FIFO_DEPTH=4.
// Expected line levels come from a per-cycle frame model written here.
module tb_tt_uart_tx;

  localparam int unsigned DIV = 4;
`ifdef TT_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_LEN = FRAME_BITS * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  tt_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level after edge k of a frame, k=1 being the edge that starts it
  function automatic logic exp_tx(input logic [7:0] d, input int k);
    if (k >= 1 && k <= DIV) return 1'b0;
    if (k <= 9 * DIV) return d[(k - DIV - 1) / DIV];
`ifdef TT_UART_TX_PARITY_EN
    if (k <= 10 * DIV) return ^d;
`endif
    return 1'b1;
  endfunction

  // Step through frame edges k0..k1 checking tx; drop ena before edge drop_at
  task automatic frame_check(input string tag, input logic [7:0] d,
                             input int k0, input int k1, input int drop_at);
    for (int k = k0; k <= k1; k++) begin
      if (k == drop_at) ena = 1'b0;
      tick();
      check($sformatf("%s_tx_k%0d", tag, k), 32'(tx), 32'(exp_tx(d, k)));
    end
  endtask

  initial begin
    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(wr_ready), 32'd1);
      check("rst_count", 32'(fifo_count), 32'd0);
    end
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();
    check("post_rst_tx", 32'(tx), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_count", 32'(fifo_count), 32'd0);

    // Single byte 0xA5: start at N+1, idle again at N+41
    wr_data = 8'hA5; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("single_count", 32'(fifo_count), 32'd1);
    check("single_tx_n", 32'(tx), 32'd1);
    frame_check("single", 8'hA5, 1, FRAME_LEN, 0);
    check("single_busy_end", 32'(busy), 32'd1);
    tick();
    check("single_busy_drop", 32'(busy), 32'd0);
    check("single_tx_idle", 32'(tx), 32'd1);

    // Back-to-back 0x00 then 0xFF with no idle gap
    wr_data = 8'h00; wr_valid = 1'b1;
    tick();
    check("b2b_count0", 32'(fifo_count), 32'd1);
    wr_data = 8'hFF;
    tick();
    wr_valid = 1'b0;
    check("b2b_count1", 32'(fifo_count), 32'd1);
    check("b2b_tx_k1", 32'(tx), 32'd0);
    frame_check("b2b0", 8'h00, 2, FRAME_LEN, 0);
    check("b2b_count2", 32'(fifo_count), 32'd1);
    frame_check("b2b1", 8'hFF, 1, 1, 0);
    check("b2b_count3", 32'(fifo_count), 32'd0);
    frame_check("b2b1", 8'hFF, 2, FRAME_LEN, 0);
    tick();
    check("b2b_busy_end", 32'(busy), 32'd0);

    // Full FIFO with ena low: fifth byte refused
    ena = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'h11 * 8'(i + 1);
      tick();
    end
    wr_valid = 1'b0;
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_ready", 32'(wr_ready), 32'd0);
    check("full_tx", 32'(tx), 32'd1);
    check("full_busy", 32'(busy), 32'd1);
    ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      frame_check($sformatf("full%0d", i), 8'h11 * 8'(i + 1), 1, FRAME_LEN, 0);
    end
    tick();
    check("full_tx_after", 32'(tx), 32'd1);
    check("full_busy_after", 32'(busy), 32'd0);
    check("full_count_after", 32'(fifo_count), 32'd0);

    // ena drops at cycle 10 of a frame; queued byte waits for ena
    wr_data = 8'h3C; wr_valid = 1'b1;
    tick();
    wr_data = 8'h5A;
    tick();
    wr_valid = 1'b0;
    check("ena_tx_k1", 32'(tx), 32'd0);
    frame_check("ena0", 8'h3C, 2, FRAME_LEN, 10);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("ena_hold_tx", 32'(tx), 32'd1);
      check("ena_hold_count", 32'(fifo_count), 32'd1);
      check("ena_hold_busy", 32'(busy), 32'd1);
    end
    ena = 1'b1;
    frame_check("ena1", 8'h5A, 1, FRAME_LEN, 0);
    tick();
    check("ena_busy_end", 32'(busy), 32'd0);

    // Asynchronous reset during data bit 3 flushes everything
    wr_data = 8'h96; wr_valid = 1'b1;
    tick();
    wr_data = 8'h69;
    tick();
    wr_valid = 1'b0;
    frame_check("rstmid", 8'h96, 2, 4 * DIV + 2, 0);
    check("rstmid_count_pre", 32'(fifo_count), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_tx", 32'(tx), 32'd1);
    check("rstmid_count", 32'(fifo_count), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < FRAME_LEN + 4; i++) begin
      tick();
      check("rstmid_quiet_tx", 32'(tx), 32'd1);
      check("rstmid_quiet_busy", 32'(busy), 32'd0);
    end

`ifdef TT_UART_TX_PARITY_EN
    // 0x07 has three ones, so the even-parity bit is 1
    wr_data = 8'h07; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    frame_check("par", 8'h07, 1, 9 * DIV, 0);
    for (int i = 0; i < DIV; i++) begin
      tick();
      check("par_bit", 32'(tx), 32'd1);
    end
    frame_check("par_stop", 8'h07, 10 * DIV + 1, 11 * DIV, 0);
    tick();
    check("par_len_busy", 32'(busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_uart_tx.md
Name: tt_uart_tx

Overview:
- Byte-serial UART transmitter for the Tiny Tapeout user design; drives one dedicated output pin (uo_out bit) toward the host-side receiver in the cocotb bench.
- Accepts bytes from core logic through a valid/ready write port.
- Buffers the bytes in a small FIFO.
- Serialises each byte as an 8N1 frame, LSB first, at a fixed clocks-per-bit rate.

Parameters:
- CLK_DIV, 16, clock cycles per serial bit; legal range 2..255.
- FIFO_DEPTH, 4, byte entries in the transmit FIFO; power of two, 2..16.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design-enable; low blocks the start of new frames
- wr_data  input  8  byte to transmit
- wr_valid  input  1  wr_data valid this cycle
- wr_ready  output  1  FIFO can accept a byte
- tx  output  1  serial line, idle high
- busy  output  1  frame in flight or FIFO non-empty
- fifo_count  output  5  current FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset (rst_n low, async):
  - tx=1, busy=0, fifo_count=0, wr_ready=1.
  - FSM=IDLE; baud counter and bit index cleared.
  - FIFO contents are don't-care.
- Write side:
  - A push occurs on a rising edge with wr_valid & wr_ready.
  - wr_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
  - Writes are accepted regardless of ena.
- Pop and count:
  - Pop happens only on the FSM start condition (below).
  - Push and pop on the same edge: count unchanged, both take effect.
  - At full, wr_ready=0, so no push occurs even if a pop happens that edge.
  - At empty, no pop.
- FSM states: IDLE, START, DATA, STOP (PARITY only with the optional feature).
  - IDLE: tx=1. If fifo_count!=0 and ena=1 on an edge: pop head into shift register, go to START, tx=0 from that edge. Baud counter loads CLK_DIV-1.
  - START: hold tx=0 for CLK_DIV cycles, then DATA with bit index 0 and tx=shift[0].
  - DATA: each bit lasts CLK_DIV cycles. After bit 7 go to STOP with tx=1.
  - STOP: tx=1 for CLK_DIV cycles. At its end, if the start condition holds, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Baud counter: counts down from CLK_DIV-1 to 0. A bit boundary is the edge where the counter is 0; the counter then reloads.
- Latency: byte pushed into an empty FIFO at edge N while IDLE with ena=1 → tx falls at edge N+1.
- Frame length: exactly 10*CLK_DIV cycles.
- ena deasserted mid-frame: the current frame completes unaltered, and no new frame starts until ena=1.
- busy = (FSM != IDLE) | (fifo_count != 0); registered-output equivalent, no glitches on tx.
- Reset mid-frame: tx returns to 1 immediately (async). Queued bytes are discarded.

Optional Feature:
- Macro: TT_UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for CLK_DIV cycles.
  - Frame length 11*CLK_DIV cycles.
- Undefined: no PARITY state, 8N1 frames of 10*CLK_DIV cycles; no parity logic synthesised.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4 unless noted):
- Reset: rst_n low for 3 cycles → tx=1, busy=0, wr_ready=1, fifo_count=0 throughout and after release.
- Single byte: push 0xA5 at edge N → tx=0 over edges N+1..N+4, then bits 1,0,1,0,0,1,0,1 each 4 cycles, then tx=1 for 4 cycles. busy drops at edge N+41.
- Back-to-back: push 0x00, 0xFF on consecutive cycles → second start bit begins exactly 40 cycles after the first, with no idle gap. fifo_count goes 1, 1 (pop+push), 1, then 0.
- Full FIFO: hold ena=0 and push 5 bytes with wr_valid held high → fifo_count=4, wr_ready=0, fifth byte not accepted. Raise ena → 4 frames are sent in order.
- ena drop mid-frame: push 0x3C, deassert ena at cycle 10 of the frame → frame completes. A second queued byte waits until ena=1, then transmits.
- Reset mid-frame: assert rst_n low during DATA bit 3 → tx=1 within the same cycle, fifo_count=0. After release, no residual frame is sent.
- With TT_UART_TX_PARITY_EN, push 0x07 → parity bit=1; frame length 44 cycles.
